// File: rtl/uart_tx_if.sv
// Byte handshake between a core-side producer and the UART transmitter.
interface uart_tx_if;
  logic [7:0] tx_data_in;
  logic       tx_valid_in;
  logic       tx_ready_out;

  modport master (
    output tx_data_in,
    output tx_valid_in,
    input  tx_ready_out
  );

  modport slave (
    input  tx_data_in,
    input  tx_valid_in,
    output tx_ready_out
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Each serial bit is held for CLKS_PER_BIT clocks; txd comes straight from a flop.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   tx_if,
  output logic       txd,
  output logic       tx_busy_out,
  output logic       tx_done_out
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            txd_q, txd_d;
  logic            done_q, done_d;

  logic cnt_last;
  logic accept;

  assign cnt_last = (cnt_q == CntW'(CLKS_PER_BIT - 1));
  assign accept   = tx_if.tx_valid_in && tx_if.tx_ready_out;

  assign tx_if.tx_ready_out = (state_q == StIdle) && !rst;
  assign tx_busy_out        = (state_q != StIdle);
  assign txd                = txd_q;
  assign tx_done_out        = done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    txd_d     = txd_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (accept) begin
          shift_d  = tx_if.tx_data_in;
          parity_d = (^tx_if.tx_data_in) ^ (PARITY_ODD != 0);
          cnt_d    = '0;
          state_d  = StStart;
          txd_d    = 1'b0;
        end
      end

      StStart: begin
        if (cnt_last) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = StData;
          txd_d     = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StData: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            if (PARITY_EN != 0) begin
              state_d = StParity;
              txd_d   = parity_q;
            end else begin
              state_d = StStop;
              txd_d   = 1'b1;
            end
          end else begin
            // The next data bit sits at shift_q[1] before the shift lands.
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StParity: begin
        if (cnt_last) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = StStop;
          txd_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StStop: begin
        txd_d = 1'b1;
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_idx_q == 3'(STOP_BITS - 1)) begin
            bit_idx_d = '0;
            state_d   = StIdle;
            done_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      txd_q     <= txd_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations driven with directed and random bytes,
// each frame compared cycle by cycle against an expected line waveform.
module tb_uart_tx;

  localparam int NumDut = 4;
  localparam int C_TAB [NumDut] = '{4, 4, 4, 2};
  localparam int P_TAB [NumDut] = '{0, 1, 1, 0};
  localparam int O_TAB [NumDut] = '{0, 0, 1, 0};
  localparam int S_TAB [NumDut] = '{1, 1, 2, 2};

  logic clk;
  logic rst;

  logic [NumDut-1:0] valid_r;
  logic [7:0]        data_r [NumDut];
  wire  [NumDut-1:0] txd_w;
  wire  [NumDut-1:0] busy_w;
  wire  [NumDut-1:0] done_w;
  wire  [NumDut-1:0] ready_w;

  int n_vec;
  int n_err;

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    uart_tx_if u_if ();

    assign u_if.tx_valid_in = valid_r[g];
    assign u_if.tx_data_in  = data_r[g];
    assign ready_w[g]       = u_if.tx_ready_out;

    uart_tx #(
      .CLKS_PER_BIT(C_TAB[g]),
      .PARITY_EN   (P_TAB[g]),
      .PARITY_ODD  (O_TAB[g]),
      .STOP_BITS   (S_TAB[g])
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .tx_if      (u_if.slave),
      .txd        (txd_w[g]),
      .tx_busy_out(busy_w[g]),
      .tx_done_out(done_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Caller has put the byte on the bus with valid high; the next edge is the accept edge.
  task automatic send_frame(input int idx, input logic [7:0] d,
                            input bit next_valid, input logic [7:0] next_d);
    bit bits[$];
    int c;
    int n;
    c = C_TAB[idx];
    n = c * (9 + P_TAB[idx] + S_TAB[idx]);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (P_TAB[idx] != 0) bits.push_back((O_TAB[idx] != 0) ? ~(^d) : (^d));
    for (int i = 0; i < S_TAB[idx]; i++) bits.push_back(1'b1);

    for (int k = 0; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (k < n) begin
        check_eq($sformatf("txd[%0d] cyc%0d", idx, k), txd_w[idx], bits[k / c]);
        check_eq($sformatf("busy[%0d]", idx), busy_w[idx], 1);
        check_eq($sformatf("ready[%0d]", idx), ready_w[idx], 0);
        check_eq($sformatf("done_early[%0d]", idx), done_w[idx], 0);
        // Mid-frame bus noise must be ignored.
        valid_r[idx] = 1'($urandom_range(0, 1));
        data_r[idx]  = 8'($urandom);
      end else begin
        check_eq($sformatf("done[%0d]", idx), done_w[idx], 1);
        check_eq($sformatf("busy_end[%0d]", idx), busy_w[idx], 0);
        check_eq($sformatf("ready_end[%0d]", idx), ready_w[idx], 1);
        check_eq($sformatf("txd_end[%0d]", idx), txd_w[idx], 1);
        valid_r[idx] = next_valid;
        data_r[idx]  = next_d;
      end
    end
  endtask

  task automatic idle_cycles(input int idx, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("idle_txd[%0d]", idx), txd_w[idx], 1);
      check_eq($sformatf("idle_busy[%0d]", idx), busy_w[idx], 0);
      check_eq($sformatf("idle_done[%0d]", idx), done_w[idx], 0);
      check_eq($sformatf("idle_ready[%0d]", idx), ready_w[idx], 1);
    end
  endtask

  task automatic run_random(input int idx, input int count);
    logic [7:0] cur;
    logic [7:0] nxt;
    bit         b2b;
    cur          = 8'($urandom);
    valid_r[idx] = 1'b1;
    data_r[idx]  = cur;
    for (int j = 0; j < count; j++) begin
      nxt = 8'($urandom);
      b2b = (j < count - 1) && ($urandom_range(0, 1) == 1);
      send_frame(idx, cur, b2b, nxt);
      if (!b2b) begin
        idle_cycles(idx, $urandom_range(1, 3));
        if (j < count - 1) begin
          valid_r[idx] = 1'b1;
          data_r[idx]  = nxt;
        end
      end
      cur = nxt;
    end
  endtask

  task automatic send_one(input int idx, input logic [7:0] d);
    valid_r[idx] = 1'b1;
    data_r[idx]  = d;
    send_frame(idx, d, 1'b0, 8'h00);
    idle_cycles(idx, 2);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    valid_r = '1;
    for (int i = 0; i < NumDut; i++) data_r[i] = 8'($urandom);

    // Reset held with valid high: nothing may be accepted.
    repeat (2) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NumDut; i++) begin
        check_eq($sformatf("rst_txd[%0d]", i), txd_w[i], 1);
        check_eq($sformatf("rst_ready[%0d]", i), ready_w[i], 0);
        check_eq($sformatf("rst_busy[%0d]", i), busy_w[i], 0);
        check_eq($sformatf("rst_done[%0d]", i), done_w[i], 0);
      end
    end
    rst     = 1'b0;
    valid_r = '0;
    #1;
    for (int i = 0; i < NumDut; i++)
      check_eq($sformatf("rel_ready[%0d]", i), ready_w[i], 1);
    for (int i = 0; i < NumDut; i++) idle_cycles(i, 1);

    // Directed single byte and back-to-back 0x00 -> 0xFF with valid held high.
    send_one(0, 8'hA5);
    valid_r[0] = 1'b1;
    data_r[0]  = 8'h00;
    send_frame(0, 8'h00, 1'b1, 8'hFF);
    send_frame(0, 8'hFF, 1'b0, 8'h00);
    idle_cycles(0, 1);

    // Reset during data bit 3, then a clean 0x3C frame.
    valid_r[0] = 1'b1;
    data_r[0]  = 8'h96;
    @(posedge clk);
    #1;
    valid_r[0] = 1'b0;
    repeat (4 * C_TAB[0] + 1) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_txd", txd_w[0], 1);
    check_eq("midrst_busy", busy_w[0], 0);
    check_eq("midrst_ready", ready_w[0], 0);
    check_eq("midrst_done", done_w[0], 0);
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      check_eq("post_rst_done", done_w[0], 0);
      check_eq("post_rst_txd", txd_w[0], 1);
    end
    send_one(0, 8'h3C);

    // Parity variants and stop-bit counts.
    send_one(1, 8'hA5);
    send_one(1, 8'h01);
    send_one(2, 8'hA5);
    send_one(3, 8'h5A);

    for (int i = 0; i < NumDut; i++) run_random(i, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
